star_motion_sequencer: RTL and testbench

- Command-level sequencer for the star hiding mechanism.
- Turns one-shot hide/show requests into the timed press/pull drive levels that the star state machine consumes.
- Watches grill and star position feedback, and supervises each motion phase with debounce, inter-phase gap and timeout.
- Sits between the operator/host command logic and the star state machine.

---
 rtl/star_motion_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_star_motion_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/star_motion_sequencer.sv
// star_motion_sequencer: turns one-shot hide/show requests into timed
// press/pull drive phases for the star state machine. Each phase is
// supervised by a settle counter, an inter-phase gap and a timeout.
// Optional build macro: STAR_SEQ_AUTO_RETRY_EN. When defined, the first
// timeout in a phase drops the drive for one gap and re-runs the same phase.
module star_motion_sequencer #(
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned SETTLE_CYCLES  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_hide,
    input  logic       i_req_show,
    input  logic       i_clr_fault,
    input  logic [1:0] i_grill_pos,
    input  logic [1:0] i_star_pos,
    output logic       o_press,
    output logic       o_pull,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LIM  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] GRILL_CLOSED = 2'b00;
    localparam logic [1:0] GRILL_OPEN   = 2'b01;
    localparam logic [1:0] STAR_UP      = 2'b00;
    localparam logic [1:0] STAR_HIDDEN  = 2'b01;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ILLEGAL = 2'b10;
    localparam logic [1:0] FC_INCONS  = 2'b11;

`ifdef STAR_SEQ_AUTO_RETRY_EN
    typedef enum logic [3:0] {
        S_IDLE, S_PH1, S_GAP1, S_PH2, S_GAP2, S_PH3, S_DONE, S_FAULT, S_RGAP
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_PH1, S_GAP1, S_PH2, S_GAP2, S_PH3, S_DONE, S_FAULT
    } state_e;
`endif

    state_e           state_q, state_d;
    logic             dir_hide_q, dir_hide_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             press_q, press_d;
    logic             pull_q, pull_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic [1:0]       code_q, code_d;
`ifdef STAR_SEQ_AUTO_RETRY_EN
    logic             retry_q, retry_d;
    state_e           rphase_q, rphase_d;
`endif

    logic [CNT_W-1:0] timer_inc_c;
    logic [CNT_W-1:0] settle_inc_c;
    logic             req_one_c;
    logic [1:0]       req_start_c;
    logic [1:0]       req_rest_c;
    logic [1:0]       star_start_c;
    logic [1:0]       star_goal_c;
    logic             tgt_hit_c;
    logic             incons_c;
    logic             drive_c;

    // Saturating increments for the phase/gap timer and the settle counter
    assign timer_inc_c  = (timer_q  == CNT_MAX) ? timer_q  : timer_q  + CNT_W'(1);
    assign settle_inc_c = (settle_q == CNT_MAX) ? settle_q : settle_q + CNT_W'(1);

    // Request decode: star position a request starts from and its rest target
    assign req_one_c   = i_req_hide ^ i_req_show;
    assign req_start_c = i_req_hide ? STAR_UP     : STAR_HIDDEN;
    assign req_rest_c  = i_req_hide ? STAR_HIDDEN : STAR_UP;

    // Star position at sequence start and at sequence end for the active direction
    assign star_start_c = dir_hide_q ? STAR_UP     : STAR_HIDDEN;
    assign star_goal_c  = dir_hide_q ? STAR_HIDDEN : STAR_UP;

    // Per-phase target condition and feedback consistency check
    always_comb begin
        tgt_hit_c = 1'b0;
        incons_c  = 1'b0;
        case (state_q)
            S_PH1: begin
                tgt_hit_c = (i_grill_pos == GRILL_OPEN);
                incons_c  = (i_star_pos != star_start_c);
            end
            S_PH2: begin
                tgt_hit_c = (i_star_pos == star_goal_c);
                incons_c  = (i_grill_pos != GRILL_OPEN);
            end
            S_PH3: begin
                tgt_hit_c = (i_grill_pos == GRILL_CLOSED);
                incons_c  = (i_star_pos != star_goal_c);
            end
            default: ;
        endcase
    end

    // Next-state, counters and registered output values
    always_comb begin
        state_d    = state_q;
        dir_hide_d = dir_hide_q;
        timer_d    = timer_q;
        settle_d   = settle_q;
        done_d     = 1'b0;
        fault_d    = fault_q;
        code_d     = code_q;
`ifdef STAR_SEQ_AUTO_RETRY_EN
        retry_d    = retry_q;
        rphase_d   = rphase_q;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d  = '0;
                settle_d = '0;
                if (req_one_c) begin
                    if (i_grill_pos == GRILL_CLOSED && i_star_pos == req_start_c) begin
                        state_d    = S_PH1;
                        dir_hide_d = i_req_hide;
`ifdef STAR_SEQ_AUTO_RETRY_EN
                        retry_d    = 1'b0;
`endif
                    end else if (i_grill_pos == GRILL_CLOSED && i_star_pos == req_rest_c) begin
                        // Already where the request wants to be: acknowledge only
                        done_d = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_ILLEGAL;
                    end
                end
            end

            S_PH1, S_PH2, S_PH3: begin
                timer_d  = timer_inc_c;
                settle_d = tgt_hit_c ? settle_inc_c : '0;
                if (incons_c) begin
                    state_d  = S_FAULT;
                    fault_d  = 1'b1;
                    code_d   = FC_INCONS;
                    timer_d  = '0;
                    settle_d = '0;
                end else if (tgt_hit_c && settle_inc_c >= SETTLE_LIM) begin
                    timer_d  = '0;
                    settle_d = '0;
                    case (state_q)
                        S_PH1:   state_d = S_GAP1;
                        S_PH2:   state_d = S_GAP2;
                        default: begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else if (timer_inc_c >= TIMEOUT_LIM) begin
                    timer_d  = '0;
                    settle_d = '0;
`ifdef STAR_SEQ_AUTO_RETRY_EN
                    if (!retry_q) begin
                        state_d  = S_RGAP;
                        rphase_d = state_q;
                        retry_d  = 1'b1;
                    end else begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                        code_d  = FC_TIMEOUT;
                    end
`else
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_TIMEOUT;
`endif
                end
            end

            S_GAP1, S_GAP2: begin
                timer_d = timer_inc_c;
                if (timer_inc_c >= GAP_LIM) begin
                    timer_d  = '0;
                    settle_d = '0;
                    state_d  = (state_q == S_GAP1) ? S_PH2 : S_PH3;
`ifdef STAR_SEQ_AUTO_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end

`ifdef STAR_SEQ_AUTO_RETRY_EN
            S_RGAP: begin
                // Retry gap: re-enter the timed-out phase, keeping the retry flag set
                timer_d = timer_inc_c;
                if (timer_inc_c >= GAP_LIM) begin
                    timer_d  = '0;
                    settle_d = '0;
                    state_d  = rphase_q;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_FAULT: begin
                timer_d  = '0;
                settle_d = '0;
                if (i_clr_fault) begin
                    state_d = S_IDLE;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        drive_c = (state_d inside {S_PH1, S_PH2, S_PH3});
        press_d = drive_c & ~dir_hide_d;
        pull_d  = drive_c &  dir_hide_d;
`ifdef STAR_SEQ_AUTO_RETRY_EN
        busy_d  = (state_d inside {S_PH1, S_GAP1, S_PH2, S_GAP2, S_PH3, S_RGAP});
`else
        busy_d  = (state_d inside {S_PH1, S_GAP1, S_PH2, S_GAP2, S_PH3});
`endif
    end

    // State, counter and output registers; reset drops the drives at once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            dir_hide_q <= 1'b0;
            timer_q    <= '0;
            settle_q   <= '0;
            press_q    <= 1'b0;
            pull_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= FC_NONE;
`ifdef STAR_SEQ_AUTO_RETRY_EN
            retry_q    <= 1'b0;
            rphase_q   <= S_IDLE;
`endif
        end else begin
            state_q    <= state_d;
            dir_hide_q <= dir_hide_d;
            timer_q    <= timer_d;
            settle_q   <= settle_d;
            press_q    <= press_d;
            pull_q     <= pull_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
`ifdef STAR_SEQ_AUTO_RETRY_EN
            retry_q    <= retry_d;
            rphase_q   <= rphase_d;
`endif
        end
    end

    assign o_press      = press_q;
    assign o_pull       = pull_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;

endmodule

// File: tb/tb_star_motion_sequencer.sv
// Bench for star_motion_sequencer: directed feedback scenarios, a
// sequence-level reference model compared every cycle, and literal timing checks.
module tb_star_motion_sequencer;

    localparam int TO  = 150;
    localparam int GAP = 16;
    localparam int SET = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_hide = 1'b0;
    logic       req_show = 1'b0;
    logic       clr_fault = 1'b0;
    logic [1:0] grill_pos = 2'b00;
    logic [1:0] star_pos = 2'b00;
    logic       o_press, o_pull, o_busy, o_done, o_fault;
    logic [1:0] o_fault_code;

    int n_cmp = 0;
    int n_bad = 0;
    int drv_cnt = 0;

    star_motion_sequencer #(
        .CNT_W(24), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .SETTLE_CYCLES(SET)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_hide(req_hide), .i_req_show(req_show), .i_clr_fault(clr_fault),
        .i_grill_pos(grill_pos), .i_star_pos(star_pos),
        .o_press(o_press), .o_pull(o_pull), .o_busy(o_busy), .o_done(o_done),
        .o_fault(o_fault), .o_fault_code(o_fault_code)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence is "active" in phase 1..3, optionally in a gap
    bit       m_active = 0, m_gap = 0, m_rgap = 0, m_hide = 0, m_done = 0;
    bit       m_fault = 0, m_retried = 0, m_blocked = 0;
    int       m_phase = 0, m_t = 0, m_settle = 0;
    logic [1:0] m_code = 2'b00;
    bit       hit, bad, blocked;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_gap = 0; m_rgap = 0; m_hide = 0; m_done = 0;
            m_fault = 0; m_retried = 0; m_blocked = 0;
            m_phase = 0; m_t = 0; m_settle = 0; m_code = 2'b00;
        end else begin
            blocked   = m_blocked;
            m_blocked = 0;
            m_done    = 0;
            if (m_fault) begin
                if (clr_fault) begin m_fault = 0; m_code = 2'b00; end
            end else if (m_active) begin
                m_t = m_t + 1;
                if (m_gap) begin
                    if (m_t >= GAP) begin
                        m_gap = 0; m_t = 0; m_settle = 0;
                        if (!m_rgap) begin m_phase = m_phase + 1; m_retried = 0; end
                        m_rgap = 0;
                    end
                end else begin
                    case (m_phase)
                        1: begin hit = (grill_pos == 2'b01); bad = (star_pos != (m_hide ? 2'b00 : 2'b01)); end
                        2: begin hit = (star_pos == (m_hide ? 2'b01 : 2'b00)); bad = (grill_pos != 2'b01); end
                        default: begin hit = (grill_pos == 2'b00); bad = (star_pos != (m_hide ? 2'b01 : 2'b00)); end
                    endcase
                    if (bad) begin
                        m_active = 0; m_fault = 1; m_code = 2'b11;
                    end else begin
                        m_settle = hit ? m_settle + 1 : 0;
                        if (m_settle >= SET) begin
                            m_t = 0; m_settle = 0;
                            if (m_phase == 3) begin m_active = 0; m_done = 1; m_blocked = 1; end
                            else m_gap = 1;
                        end else if (m_t >= TO) begin
                            m_t = 0; m_settle = 0;
`ifdef STAR_SEQ_AUTO_RETRY_EN
                            if (!m_retried) begin m_retried = 1; m_gap = 1; m_rgap = 1; end
                            else begin m_active = 0; m_fault = 1; m_code = 2'b01; end
`else
                            m_active = 0; m_fault = 1; m_code = 2'b01;
`endif
                        end
                    end
                end
            end else if (!blocked && (req_hide ^ req_show)) begin
                if (grill_pos == 2'b00 && star_pos == (req_hide ? 2'b00 : 2'b01)) begin
                    m_active = 1; m_hide = req_hide; m_phase = 1; m_gap = 0; m_rgap = 0;
                    m_t = 0; m_settle = 0; m_retried = 0;
                end else if (grill_pos == 2'b00 && star_pos == (req_hide ? 2'b01 : 2'b00)) begin
                    m_done = 1;
                end else begin
                    m_fault = 1; m_code = 2'b10;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge and compare against the model
    task automatic step();
        @(negedge clk);
        chk("press", int'(o_press), int'(m_active && !m_gap && !m_hide));
        chk("pull",  int'(o_pull),  int'(m_active && !m_gap &&  m_hide));
        chk("busy",  int'(o_busy),  int'(m_active));
        chk("done",  int'(o_done),  int'(m_done));
        chk("fault", int'(o_fault), int'(m_fault));
        chk("code",  int'(o_fault_code), int'(m_code));
        if (o_press || o_pull) drv_cnt++;
    endtask

    task automatic hold(input logic [1:0] g, input logic [1:0] s, input int n);
        grill_pos = g;
        star_pos  = s;
        repeat (n) step();
    endtask

    // Phase just entered: feedback moving for n_mov cycles, then on target
    task automatic run_phase(input logic [1:0] gm, input logic [1:0] sm,
                             input logic [1:0] gt, input logic [1:0] st,
                             input int n_mov, input int exp_hi);
        drv_cnt = 1;
        hold(gm, sm, n_mov);
        hold(gt, st, SET - 1);
        chk("phase_drive_before_settle", int'(o_press | o_pull), 1);
        hold(gt, st, 1);
        chk("phase_drive_drop", int'(o_press | o_pull), 0);
        chk("phase_drive_cycles", drv_cnt, exp_hi);
    endtask

    task automatic run_gap(input logic [1:0] g, input logic [1:0] s);
        hold(g, s, GAP - 1);
        chk("gap_drive_low", int'(o_press | o_pull), 0);
        hold(g, s, 1);
        chk("gap_next_phase_drive", int'(o_press | o_pull), 1);
    endtask

    task automatic request(input bit hide);
        if (hide) req_hide = 1'b1; else req_show = 1'b1;
        step();
        req_hide = 1'b0;
        req_show = 1'b0;
    endtask

    task automatic clear_fault();
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        chk("clr_fault_flag", int'(o_fault), 0);
        chk("clr_fault_code", int'(o_fault_code), 0);
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_fault", int'(o_fault), 0);
        chk("reset_pull", int'(o_pull), 0);
        rst_n = 1'b1;
        step();

        // Hide: three 100-cycle phases, requests while busy ignored
        hold(2'b00, 2'b00, 1);
        request(1'b1);
        chk("hide_first_pull", int'(o_pull), 1);
        chk("hide_first_busy", int'(o_busy), 1);
        req_show = 1'b1;
        run_phase(2'b10, 2'b00, 2'b01, 2'b00, 100, 104);
        req_show = 1'b0;
        run_gap(2'b01, 2'b10);
        run_phase(2'b01, 2'b10, 2'b01, 2'b01, 100, 104);
        run_gap(2'b10, 2'b01);
        run_phase(2'b10, 2'b01, 2'b00, 2'b01, 100, 104);
        chk("hide_done_pulse", int'(o_done), 1);
        chk("hide_done_busy", int'(o_busy), 0);
        step();
        chk("hide_done_once", int'(o_done), 0);

        // Show with a 3-cycle target glitch in phase 1
        hold(2'b00, 2'b01, 1);
        request(1'b0);
        chk("show_first_press", int'(o_press), 1);
        hold(2'b10, 2'b01, 10);
        hold(2'b01, 2'b01, 3);
        chk("glitch_keeps_phase", int'(o_press), 1);
        hold(2'b10, 2'b01, 2);
        hold(2'b01, 2'b01, 3);
        chk("settle_restarted", int'(o_press), 1);
        hold(2'b01, 2'b01, 1);
        chk("settle_ends_phase", int'(o_press), 0);
        run_gap(2'b01, 2'b10);
        run_phase(2'b01, 2'b10, 2'b01, 2'b00, 20, 24);
        run_gap(2'b10, 2'b00);
        run_phase(2'b10, 2'b00, 2'b00, 2'b00, 20, 24);
        chk("show_done_pulse", int'(o_done), 1);
        step();

        // Show while already at rest: acknowledge without motion
        request(1'b0);
        chk("rest_done", int'(o_done), 1);
        chk("rest_no_busy", int'(o_busy), 0);
        hold(2'b00, 2'b00, 2);

        // Illegal start
        grill_pos = 2'b10;
        request(1'b1);
        chk("illegal_fault", int'(o_fault), 1);
        chk("illegal_code", int'(o_fault_code), 2);
        chk("illegal_no_pull", int'(o_pull), 0);
        hold(2'b00, 2'b00, 2);
        clear_fault();

        // Both requests together are ignored; clear outside fault does nothing
        req_hide = 1'b1; req_show = 1'b1;
        step();
        req_hide = 1'b0; req_show = 1'b0;
        chk("both_req_busy", int'(o_busy), 0);
        chk("both_req_done", int'(o_done), 0);
        clr_fault = 1'b1; step(); clr_fault = 1'b0;
        hold(2'b00, 2'b00, 2);

        // Star leaves its position during hide phase 1
        request(1'b1);
        hold(2'b10, 2'b00, 10);
        hold(2'b10, 2'b10, 1);
        chk("incons_fault", int'(o_fault), 1);
        chk("incons_code", int'(o_fault_code), 3);
        chk("incons_pull_drop", int'(o_pull), 0);
        hold(2'b00, 2'b00, 2);
        clear_fault();

        // Feedback frozen in phase 2 until timeout
        request(1'b1);
        run_phase(2'b10, 2'b00, 2'b01, 2'b00, 5, 9);
        run_gap(2'b01, 2'b10);
        hold(2'b01, 2'b10, TO - 1);
        chk("timeout_drive_held", int'(o_pull), 1);
        hold(2'b01, 2'b10, 1);
        chk("timeout_drive_drop", int'(o_pull), 0);
`ifdef STAR_SEQ_AUTO_RETRY_EN
        chk("retry_no_fault", int'(o_fault), 0);
        chk("retry_busy", int'(o_busy), 1);
        run_gap(2'b01, 2'b10);
        hold(2'b01, 2'b10, TO - 1);
        chk("retry_drive_held", int'(o_pull), 1);
        hold(2'b01, 2'b10, 1);
        chk("retry_drive_drop", int'(o_pull), 0);
`endif
        chk("timeout_fault", int'(o_fault), 1);
        chk("timeout_code", int'(o_fault_code), 1);
        hold(2'b00, 2'b00, 2);
        request(1'b1);
        chk("fault_ignores_req", int'(o_pull), 0);
        chk("fault_sticky", int'(o_fault), 1);
        clear_fault();
        step();

        // Asynchronous reset in the middle of phase 2
        request(1'b1);
        run_phase(2'b10, 2'b00, 2'b01, 2'b00, 5, 9);
        run_gap(2'b01, 2'b10);
        hold(2'b01, 2'b10, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pull", int'(o_pull), 0);
        chk("async_rst_busy", int'(o_busy), 0);
        hold(2'b00, 2'b00, 3);
        rst_n = 1'b1;
        step();
        request(1'b1);
        chk("post_reset_accept", int'(o_pull), 1);
        hold(2'b10, 2'b00, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
